// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Configurable-width program-counter unit. Each rising edge it picks the
// next PC from sequential, branch, JAL, JALR or MRET flow. It also handles
// stall, trap entry with a saved EPC, misaligned-target exceptions, fetch
// redirect signalling and a retired-instruction counter.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   stall       in   hold PC, EPC and counter this cycle (trap still wins)
//   func[2:0]   in   000 seq, 001 branch, 010 jal, 011 jalr, 100 mret,
//                    101-111 behave as seq
//   taken       in   branch outcome, only meaningful when func = branch
//   imm         in   sign-extended immediate
//   rs1_val     in   rs1 operand, used by jalr
//   trap        in   take a trap this cycle
//   pcout       out  current PC (registered)
//   pc_plus4    out  pcout + 4 (combinational link value)
//   epc         out  saved exception PC (registered)
//   misaligned  out  one-cycle pulse after a misaligned jump target
//   redirect    out  high in the cycle after any non-sequential PC load
//   instret     out  retired-instruction count (wraps)
//
// Interface timing: every control input is sampled on the rising edge.
// There is no handshake. The new PC, and the redirect/misaligned flags
// that describe it, are all visible together one cycle after the inputs.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h100,
    parameter int              CNT_W        = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       func,
    input  logic             taken,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic             trap,
    output logic [XLEN-1:0]  pcout,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  epc,
    output logic             misaligned,
    output logic             redirect,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] FUNC_SEQ    = 3'b000;
    localparam logic [2:0] FUNC_BRANCH = 3'b001;
    localparam logic [2:0] FUNC_JAL    = 3'b010;
    localparam logic [2:0] FUNC_JALR   = 3'b011;
    localparam logic [2:0] FUNC_MRET   = 3'b100;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic            misaligned_q;
    logic            redirect_q;
    logic [CNT_W-1:0] instret_q;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic            is_jump;
    logic            needs_align_chk;
    logic            bad_target;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Target selection. is_jump marks every non-sequential load (it drives
    // redirect). needs_align_chk is limited to the computed targets: MRET
    // returns to epc, which is taken as-is.
    always_comb begin
        target          = pc_plus4;
        jalr_sum        = rs1_val + imm;
        is_jump         = 1'b0;
        needs_align_chk = 1'b0;
        case (func)
            FUNC_BRANCH: begin
                if (taken) begin
                    target          = pc_q + imm;
                    is_jump         = 1'b1;
                    needs_align_chk = 1'b1;
                end
            end
            FUNC_JAL: begin
                target          = pc_q + imm;
                is_jump         = 1'b1;
                needs_align_chk = 1'b1;
            end
            FUNC_JALR: begin
                target          = {jalr_sum[XLEN-1:1], 1'b0};
                is_jump         = 1'b1;
                needs_align_chk = 1'b1;
            end
            FUNC_MRET: begin
                target  = epc_q;
                is_jump = 1'b1;
            end
            FUNC_SEQ: ;
            default: ;   // reserved codes fall through as sequential
        endcase
        // Bit 0 is either cleared (jalr) or an even immediate is assumed,
        // so only bit 1 decides 4-byte alignment.
        bad_target = needs_align_chk & target[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            misaligned_q <= 1'b0;
            redirect_q   <= 1'b0;
            instret_q    <= '0;
        end else if (trap) begin
            epc_q        <= pc_q;
            pc_q         <= TRAP_VECTOR;
            misaligned_q <= 1'b0;
            redirect_q   <= 1'b1;
        end else if (stall) begin
            misaligned_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else if (bad_target) begin
            // Misaligned target: the jump does not retire, so it is not counted.
            epc_q        <= pc_q;
            pc_q         <= TRAP_VECTOR;
            misaligned_q <= 1'b1;
            redirect_q   <= 1'b1;
        end else begin
            pc_q         <= target;
            misaligned_q <= 1'b0;
            redirect_q   <= is_jump;
            instret_q    <= instret_q + CNT_W'(1);
        end
    end

    assign pcout      = pc_q;
    assign epc        = epc_q;
    assign misaligned = misaligned_q;
    assign redirect   = redirect_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//
// Directed testbench for pc_unit with the default parameters: XLEN = 32,
// RESET_VECTOR = 0, TRAP_VECTOR = 0x100 and CNT_W = 64.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic             stall;
    logic [2:0]       func;
    logic             taken;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_val;
    logic             trap;
    logic [XLEN-1:0]  pcout;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  epc;
    logic             misaligned;
    logic             redirect;
    logic [CNT_W-1:0] instret;

    pc_unit #(
        .XLEN(XLEN),
        .RESET_VECTOR(32'h0),
        .TRAP_VECTOR(32'h100),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .func(func),
        .taken(taken),
        .imm(imm),
        .rs1_val(rs1_val),
        .trap(trap),
        .pcout(pcout),
        .pc_plus4(pc_plus4),
        .epc(epc),
        .misaligned(misaligned),
        .redirect(redirect),
        .instret(instret)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of controls and queue the expected next PC. After the
    // edge, pop that expectation and compare it with pcout.
    task automatic run(input string tag, input logic rst, input logic [2:0] f,
                       input logic tk, input logic [XLEN-1:0] im,
                       input logic [XLEN-1:0] r1, input logic tr,
                       input logic st, input logic [XLEN-1:0] exp_pc);
        logic [XLEN-1:0] e;
        reset   = rst;
        func    = f;
        taken   = tk;
        imm     = im;
        rs1_val = r1;
        trap    = tr;
        stall   = st;
        exp_q.push_back(exp_pc);
        step();
        e = exp_q.pop_front();
        check_val(tag, 64'(pcout), 64'(e));
    endtask

    localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JAL = 3'b010,
                           JALR = 3'b011, MRET = 3'b100;

    initial begin
        reset = 1'b1; stall = 1'b0; func = SEQ; taken = 1'b0;
        imm = '0; rs1_val = '0; trap = 1'b0;
        step();
        step();
        check_val("rst_pc",       64'(pcout),    64'h0);
        check_val("rst_pc_plus4", 64'(pc_plus4), 64'h4);
        check_val("rst_epc",      64'(epc),      64'h0);
        check_val("rst_mis",      64'(misaligned), 64'h0);
        check_val("rst_redir",    64'(redirect), 64'h0);
        check_val("rst_instret",  instret,       64'h0);

        // Three sequential cycles.
        run("seq1", 0, SEQ, 0, 0, 0, 0, 0, 32'h4);
        check_val("seq1_redir", 64'(redirect), 0);
        run("seq2", 0, SEQ, 0, 0, 0, 0, 0, 32'h8);
        run("seq3", 0, SEQ, 0, 0, 0, 0, 0, 32'hC);
        check_val("seq3_redir", 64'(redirect), 0);
        check_val("seq3_plus4", 64'(pc_plus4), 64'h10);
        check_val("seq3_instret", instret, 64'd3);

        // Taken branch backwards from 0x10.
        run("seq4", 0, SEQ, 0, 0, 0, 0, 0, 32'h10);
        run("br_taken", 0, BR, 1, 32'hFFFF_FFF8, 0, 0, 0, 32'h08);
        check_val("br_taken_redir", 64'(redirect), 1);
        check_val("br_taken_instret", instret, 64'd5);
        run("seq5", 0, SEQ, 0, 0, 0, 0, 0, 32'h0C);
        check_val("seq5_redir", 64'(redirect), 0);
        run("seq6", 0, SEQ, 0, 0, 0, 0, 0, 32'h10);
        run("br_not_taken", 0, BR, 0, 32'hFFFF_FFF8, 0, 0, 0, 32'h14);
        check_val("br_nt_redir", 64'(redirect), 0);
        check_val("br_nt_instret", instret, 64'd8);

        // Reach 0x20 with jal, then jalr clears bit 0, then misaligned jal.
        run("jal_0x20", 0, JAL, 0, 32'hC, 0, 0, 0, 32'h20);
        check_val("jal_redir", 64'(redirect), 1);
        run("jalr", 0, JALR, 0, 32'h3, 32'h2001, 0, 0, 32'h2004);
        check_val("jalr_redir", 64'(redirect), 1);
        check_val("jalr_mis", 64'(misaligned), 0);
        run("jal_mis", 0, JAL, 0, 32'h6, 0, 0, 0, 32'h100);
        check_val("jal_mis_flag", 64'(misaligned), 1);
        check_val("jal_mis_epc", 64'(epc), 64'h2004);
        check_val("jal_mis_redir", 64'(redirect), 1);
        check_val("jal_mis_instret", instret, 64'd10);
        run("after_mis", 0, SEQ, 0, 0, 0, 0, 0, 32'h104);
        check_val("after_mis_flag", 64'(misaligned), 0);
        check_val("after_mis_instret", instret, 64'd11);

        // Trap overrides stall at 0x40, then mret returns.
        run("jalr_0x40", 0, JALR, 0, 0, 32'h40, 0, 0, 32'h40);
        run("trap_stall", 0, SEQ, 0, 0, 0, 1, 1, 32'h100);
        check_val("trap_epc", 64'(epc), 64'h40);
        check_val("trap_redir", 64'(redirect), 1);
        check_val("trap_instret", instret, 64'd12);
        run("mret", 0, MRET, 0, 0, 0, 0, 0, 32'h40);
        check_val("mret_redir", 64'(redirect), 1);
        check_val("mret_instret", instret, 64'd13);

        // Wrap below zero and back.
        run("jalr_0", 0, JALR, 0, 0, 0, 0, 0, 32'h0);
        run("jal_neg", 0, JAL, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC);
        check_val("wrap_plus4", 64'(pc_plus4), 64'h0);
        run("seq_wrap", 0, SEQ, 0, 0, 0, 0, 0, 32'h0);
        check_val("seq_wrap_instret", instret, 64'd16);

        // Reset with a simultaneous trap at 0x80: the trap is discarded.
        run("jalr_0x80", 0, JALR, 0, 0, 32'h80, 0, 0, 32'h80);
        run("rst_trap", 1, SEQ, 0, 0, 0, 1, 0, 32'h0);
        check_val("rst_trap_epc", 64'(epc), 64'h0);
        check_val("rst_trap_redir", 64'(redirect), 0);
        check_val("rst_trap_instret", instret, 64'd0);

        // mret with epc never written jumps to 0.
        run("seq_a", 0, SEQ, 0, 0, 0, 0, 0, 32'h4);
        run("mret_zero", 0, MRET, 0, 0, 0, 0, 0, 32'h0);
        run("seq_b", 0, SEQ, 0, 0, 0, 0, 0, 32'h4);
        check_val("seq_b_instret", instret, 64'd3);

        // A jal then a 5-cycle stall: the stalled jal is not latched, and
        // the stall drops redirect.
        run("jal_pre_stall", 0, JAL, 0, 32'h10, 0, 0, 0, 32'h14);
        for (int i = 0; i < 5; i++) begin
            run("stall_pc", 0, JAL, 0, 32'h40, 0, 0, 1, 32'h14);
            check_val("stall_instret", instret, 64'd4);
            check_val("stall_redir", 64'(redirect), 0);
        end
        run("post_stall", 0, SEQ, 0, 0, 0, 0, 0, 32'h18);
        check_val("post_stall_instret", instret, 64'd5);

        // Reserved func codes behave as seq, including the count.
        run("rsvd_111", 0, 3'b111, 1, 32'h40, 32'h40, 0, 0, 32'h1C);
        check_val("rsvd_redir", 64'(redirect), 0);
        check_val("rsvd_instret", instret, 64'd6);

        // Back-to-back traps each capture the PC at their own edge.
        run("trap1", 0, SEQ, 0, 0, 0, 1, 0, 32'h100);
        check_val("trap1_epc", 64'(epc), 64'h1C);
        run("trap2", 0, SEQ, 0, 0, 0, 1, 0, 32'h100);
        check_val("trap2_epc", 64'(epc), 64'h100);
        check_val("trap2_instret", instret, 64'd6);

        // Misaligned taken branch.
        run("br_mis", 0, BR, 1, 32'h2, 0, 0, 0, 32'h100);
        check_val("br_mis_flag", 64'(misaligned), 1);
        check_val("br_mis_epc", 64'(epc), 64'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RISC-V core. It replaces the fixed 32-bit PC with a configurable-width block that resolves sequential, branch, JAL, JALR and trap-return flow. It also handles stall, trap entry with a saved EPC, misaligned-target exceptions, fetch-redirect signalling and a retired-instruction counter. It sits between decode/execute, which supply the control, immediate and operand, and instruction fetch, which consumes the PC and the redirect flag.

## Interface
- XLEN, 32, PC/operand width (≥ 8)
- RESET_VECTOR, 0, PC value after reset
- TRAP_VECTOR, 32'h100, PC loaded on trap or misaligned target (4-byte aligned)
- CNT_W, 64, width of the retired-instruction counter
- clock  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold PC and counter this cycle
- func  in  3  000 seq, 001 branch, 010 jal, 011 jalr, 100 mret, 101–111 treated as seq
- taken  in  1  branch outcome, used only when func=001
- imm  in  XLEN  sign-extended immediate
- rs1_val  in  XLEN  rs1 register value, used for JALR
- trap  in  1  take trap this cycle
- pcout  out  XLEN  current PC, registered
- pc_plus4  out  XLEN  pcout+4, combinational link value
- epc  out  XLEN  saved exception PC, registered
- misaligned  out  1  one-cycle pulse, registered
- redirect  out  1  registered; 1 in the cycle after any non-sequential PC load
- instret  out  CNT_W  retired-instruction count, registered

## Operation
- Target computation, all modulo 2^XLEN:
  - seq: pc+4
  - branch: pc+imm if taken, else pc+4
  - jal: pc+imm
  - jalr: (rs1_val+imm) with bit 0 cleared
  - mret: epc
- Misalignment check applies to the target of taken branch, jal and jalr only.
  - Target bit 1 set → no jump. Instead: epc←pc, pc←TRAP_VECTOR, misaligned←1, redirect←1. instret does not increment.
- Per-edge priority, highest first:
  1. reset: pcout←RESET_VECTOR, epc←0, misaligned←0, redirect←0, instret←0.
  2. trap: epc←pcout, pcout←TRAP_VECTOR, redirect←1. Overrides stall. instret unchanged.
  3. stall: all state holds. misaligned←0, redirect←0.
  4. func: pcout←target, or the trap vector on misalignment.
     - redirect←1 for taken branch, jal, jalr and mret; 0 for seq and not-taken branch.
     - instret←instret+1, except on misalignment.
- misaligned is 0 in every cycle except the one following a misaligned event.
- mret with epc never written jumps to 0. This is legal.
- Arithmetic wraps silently. No overflow flag.
- instret wraps at 2^CNT_W to 0.
- Reserved func codes behave exactly as seq, including the instret increment.

## Timing
- All outputs except pc_plus4 are updated on the rising clock edge. Latency is 1 cycle from the control inputs to the new pcout.
- pc_plus4 follows pcout combinationally in the same cycle.
- redirect and misaligned are asserted in the same cycle as the new pcout they describe.
- Reset values:
  - pcout = RESET_VECTOR
  - pc_plus4 = RESET_VECTOR+4
  - epc, misaligned, redirect, instret = 0
- Reset asserted mid-stall or mid-trap wins that edge. Trap in the same edge as reset is discarded.
- Back-to-back traps each overwrite epc with the PC current at that edge.
- A stall lasting N cycles holds pcout for exactly N cycles. No control input is latched during a stall.

## Test plan
Defaults: XLEN=32, RESET_VECTOR=0, TRAP_VECTOR=0x100.
- Reset, then 3 seq cycles → pcout 0, 4, 8, 0xC; instret=3; redirect stays 0.
- At pc=0x10, branch taken imm=-8 → pcout=0x08, redirect=1 for one cycle. Same at 0x10 not taken → 0x14, redirect=0.
- At pc=0x20, jalr rs1_val=0x2001 imm=3 → pcout=0x2004. Then jal imm=6 → misaligned=1, epc=0x2004, pcout=0x100, instret not incremented.
- At pc=0x40, trap with stall=1 → epc=0x40, pcout=0x100. Then mret → pcout=0x40, redirect=1.
- At pc=0, jal imm=-4 → pcout=0xFFFFFFFC. Then seq → pcout=0 (wrap).
- reset and trap in the same cycle at pc=0x80 → pcout=0, epc=0. Stall held 5 cycles → pcout constant, instret constant.
